// File: rtl/i4003_loader_pkg.sv
// i4003_loader_pkg: shared state type and cycle-math helpers for the i4003 serial loader
package i4003_loader_pkg;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, TAIL} state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // nanoseconds to whole sysclk cycles, rounded up and never below one cycle
    function automatic int nstocy(input int ns, input int tcy);
        int c;
        c = (ns + tcy - 1) / tcy;
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/i4003_loader_if.sv
// i4003_loader_if: parallel load handshake between the CPU-side port logic and the loader
interface i4003_loader_if #(parameter int W = 10) ();
    logic [W-1:0] load_data;
    logic         load_valid;
    logic         load_ready;

    modport master (output load_data, load_valid, input load_ready);
    modport slave  (input load_data, load_valid, output load_ready);
endinterface

// File: rtl/i4003_phase_timer.sv
// i4003_phase_timer: loadable down-counter timing the cp low, cp high and tail phases
module i4003_phase_timer #(
    parameter int PW = 5
) (
    input  logic          sysclk,
    input  logic          reset,
    input  logic          load,
    input  logic [PW-1:0] value,
    output logic          tc
);
    logic [PW-1:0] cnt;

    always_ff @(posedge sysclk or posedge reset)
        if (reset)             cnt <= '0;
        else if (load)         cnt <= value;
        else if (cnt != '0)    cnt <= cnt - 1'b1;

    assign tc = (cnt == '0);
endmodule

// File: rtl/i4003_loader.sv
// i4003_loader: shifts a parallel word MSB first into a chain of i4003s, then raises enable
module i4003_loader
    import i4003_loader_pkg::*;
#(
    parameter int SYSCLK_TCY = 20,
    parameter int CHAIN_LEN  = 1,
    parameter int CP_HIGH_NS = 400,
    parameter int CP_LOW_NS  = 400,
    parameter int BLANK      = 1
) (
    input  logic                 sysclk,
    input  logic                 reset,
    i4003_loader_if.slave        bus,
    output logic                 cp,
    output logic                 serial_in,
    output logic                 enable_out,
    output logic                 busy,
    output logic                 done
);
    localparam int W   = 10 * CHAIN_LEN;
    localparam int L   = nstocy(CP_LOW_NS, SYSCLK_TCY);
    localparam int H   = nstocy(CP_HIGH_NS, SYSCLK_TCY);
    localparam int PWR = clog2((L > H) ? L : H);
    localparam int PW  = (PWR < 1) ? 1 : PWR;
    localparam int BW  = clog2(W + 1);
    localparam logic [BW-1:0] LAST = BW'(W - 1);

    state_t        state;
    logic [W-1:0]  hold;
    logic [BW-1:0] bitcnt;
    logic          tc;
    logic          tload;
    logic [PW-1:0] tval;

    assign bus.load_ready = (state == IDLE);
    assign busy           = (state != IDLE);
    // the timer reloads on every phase change; only HIGH lasts H cycles, LOW and TAIL last L
    assign tload = (state == IDLE) ? bus.load_valid : tc;
    assign tval  = (state == LOW) ? PW'(H - 1) : PW'(L - 1);

    i4003_phase_timer #(.PW(PW)) u_timer (
        .sysclk (sysclk),
        .reset  (reset),
        .load   (tload),
        .value  (tval),
        .tc     (tc)
    );

    always_ff @(posedge sysclk or posedge reset)
        if (reset) begin
            state      <= IDLE;
            hold       <= '0;
            bitcnt     <= '0;
            cp         <= 1'b0;
            serial_in  <= 1'b0;
            enable_out <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (bus.load_valid) begin
                    hold      <= bus.load_data;
                    serial_in <= bus.load_data[W-1];
                    bitcnt    <= '0;
                    state     <= LOW;
                    if (BLANK != 0) enable_out <= 1'b0;
                end
                LOW: if (tc) begin
                    cp    <= 1'b1;
                    state <= HIGH;
                end
                HIGH: if (tc) begin
                    cp     <= 1'b0;
                    bitcnt <= bitcnt + 1'b1;
                    if (bitcnt == LAST) state <= TAIL;
                    else begin
                        // next bit goes out on the same edge cp falls
                        hold      <= hold << 1;
                        serial_in <= hold[W-2];
                        state     <= LOW;
                    end
                end
                TAIL: if (tc) begin
                    enable_out <= 1'b1;
                    done       <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
endmodule

// File: tb/tb_i4003_loader.sv
// tb_i4003_loader: directed checks of the loader against a behavioural i4003 chain model
module tb_i4003_loader;
    logic sysclk = 1'b0;
    always #10 sysclk = ~sysclk;

    logic rst_a, rst_b, rst_c;
    logic cp_a, si_a, en_a, busy_a, done_a;
    logic cp_b, si_b, en_b, busy_b, done_b;
    logic cp_c, si_c, en_c, busy_c, done_c;

    i4003_loader_if #(.W(10)) a_if ();
    i4003_loader_if #(.W(20)) b_if ();
    i4003_loader_if #(.W(10)) c_if ();

    i4003_loader u_a (
        .sysclk(sysclk), .reset(rst_a), .bus(a_if), .cp(cp_a), .serial_in(si_a),
        .enable_out(en_a), .busy(busy_a), .done(done_a)
    );
    i4003_loader #(.CHAIN_LEN(2)) u_b (
        .sysclk(sysclk), .reset(rst_b), .bus(b_if), .cp(cp_b), .serial_in(si_b),
        .enable_out(en_b), .busy(busy_b), .done(done_b)
    );
    i4003_loader #(.SYSCLK_TCY(100), .CP_HIGH_NS(300)) u_c (
        .sysclk(sysclk), .reset(rst_c), .bus(c_if), .cp(cp_c), .serial_in(si_c),
        .enable_out(en_c), .busy(busy_c), .done(done_c)
    );

    // i4003 chain model: data latched while cp is high, shifted in on the falling edge
    logic lat_a, lat_b, lat_c;
    logic [9:0]  ch_a, ch_c;
    logic [19:0] ch_b;
    always @(posedge cp_a) lat_a <= si_a;
    always @(negedge cp_a) ch_a  <= {ch_a[8:0], lat_a};
    always @(posedge cp_b) lat_b <= si_b;
    always @(negedge cp_b) ch_b  <= {ch_b[18:0], lat_b};
    always @(posedge cp_c) lat_c <= si_c;
    always @(negedge cp_c) ch_c  <= {ch_c[8:0], lat_c};

    int n_run, n_fail;
    int rises, hmin, hmax, lmin, si_bad, en_seen, rdy_bad, lat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic f_cp(input int s);
        return (s == 0) ? cp_a : (s == 1) ? cp_b : cp_c;
    endfunction
    function automatic logic f_si(input int s);
        return (s == 0) ? si_a : (s == 1) ? si_b : si_c;
    endfunction
    function automatic logic f_done(input int s);
        return (s == 0) ? done_a : (s == 1) ? done_b : done_c;
    endfunction
    function automatic logic f_en(input int s);
        return (s == 0) ? en_a : (s == 1) ? en_b : en_c;
    endfunction
    function automatic logic f_rdy(input int s);
        return (s == 0) ? a_if.load_ready : (s == 1) ? b_if.load_ready : c_if.load_ready;
    endfunction

    task automatic drive(input int s, input logic [19:0] d, input logic v);
        if (s == 0) begin a_if.load_data = d[9:0]; a_if.load_valid = v; end
        else if (s == 1) begin b_if.load_data = d; b_if.load_valid = v; end
        else begin c_if.load_data = d[9:0]; c_if.load_valid = v; end
    endtask

    // called at a falling edge; returns at the falling edge of the done cycle (lat = cycle number)
    task automatic run_load(input int s, input logic [19:0] d, input bit hold);
        logic prev, sp, c, x;
        int hrun, lrun;
        rises = 0; hmin = 9999; hmax = 0; lmin = 9999;
        si_bad = 0; en_seen = 0; rdy_bad = 0; lat = -1;
        chk("ready_before_accept", 32'(f_rdy(s)), 1);
        drive(s, d, 1'b1);
        @(posedge sysclk);
        @(negedge sysclk);
        if (!hold) drive(s, d, 1'b0);
        prev = 1'b0; sp = f_si(s); hrun = 0; lrun = 0;
        for (int n = 1; n <= 2000; n++) begin
            if (f_done(s)) begin lat = n; break; end
            c = f_cp(s);
            x = f_si(s);
            if (n > 1 && x !== sp && !(prev && !c)) si_bad++;
            if (c && !prev) begin
                rises++;
                if (lrun < lmin) lmin = lrun;
                hrun = 0;
            end
            if (!c && prev) begin
                if (hrun < hmin) hmin = hrun;
                if (hrun > hmax) hmax = hrun;
                lrun = 0;
            end
            if (c) hrun++; else lrun++;
            prev = c;
            sp = x;
            if (f_en(s)) en_seen++;
            if (f_rdy(s)) rdy_bad++;
            if (hold) drive(s, d ^ 20'(n * 37), 1'b1);
            @(negedge sysclk);
        end
        if (hold) drive(s, d, 1'b0);
    endtask

    initial begin
        n_run = 0; n_fail = 0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        drive(0, 0, 1'b0); drive(1, 0, 1'b0); drive(2, 0, 1'b0);
        repeat (3) @(negedge sysclk);
        chk("rst_cp", 32'(cp_a), 0);
        chk("rst_si", 32'(si_a), 0);
        chk("rst_en", 32'(en_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_ready", 32'(a_if.load_ready), 1);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        @(negedge sysclk);

        run_load(0, 20'h2A5, 1'b0);
        chk("single_latency", 32'(lat), 421);
        chk("single_chain", 32'(ch_a), 32'h2A5);
        chk("single_enable", 32'(en_a), 1);
        chk("single_rises", 32'(rises), 10);
        chk("single_hmin", 32'(hmin), 20);
        chk("single_hmax", 32'(hmax), 20);
        chk("single_lmin_ok", 32'(lmin >= 20), 1);
        chk("single_si_stable", 32'(si_bad), 0);
        chk("single_ready_low", 32'(rdy_bad), 0);
        @(negedge sysclk);
        chk("done_one_cycle", 32'(done_a), 0);
        chk("idle_busy", 32'(busy_a), 0);

        run_load(0, 20'h3FF, 1'b0);
        chk("b2b1_latency", 32'(lat), 421);
        chk("b2b1_chain", 32'(ch_a), 32'h3FF);
        chk("b2b1_enable", 32'(en_a), 1);
        run_load(0, 20'h000, 1'b0);
        chk("b2b2_latency", 32'(lat), 421);
        chk("b2b2_blanked", 32'(en_seen), 0);
        chk("b2b2_chain", 32'(ch_a), 32'h000);

        run_load(0, 20'h12C, 1'b1);
        chk("hold_latency", 32'(lat), 421);
        chk("hold_ready_low", 32'(rdy_bad), 0);
        chk("hold_ready_done", 32'(a_if.load_ready), 1);
        chk("hold_chain", 32'(ch_a), 32'h12C);
        @(negedge sysclk);
        chk("hold_no_requeue", 32'(busy_a), 0);

        drive(0, 20'h0F0, 1'b1);
        @(posedge sysclk);
        @(negedge sysclk);
        drive(0, 0, 1'b0);
        repeat (224) @(negedge sysclk);
        chk("bit5_cp_high", 32'(cp_a), 1);
        chk("bit5_si", 32'(si_a), 1);
        rst_a = 1'b1;
        #1;
        chk("midrst_cp", 32'(cp_a), 0);
        chk("midrst_si", 32'(si_a), 0);
        chk("midrst_en", 32'(en_a), 0);
        chk("midrst_ready", 32'(a_if.load_ready), 1);
        chk("midrst_busy", 32'(busy_a), 0);
        @(negedge sysclk);
        rst_a = 1'b0;
        @(negedge sysclk);
        run_load(0, 20'h155, 1'b0);
        chk("after_rst_latency", 32'(lat), 421);
        chk("after_rst_chain", 32'(ch_a), 32'h155);

        run_load(1, 20'hABCDE, 1'b0);
        chk("chain2_latency", 32'(lat), 821);
        chk("chain2_rises", 32'(rises), 20);
        chk("chain2_chip0", 32'(ch_b[9:0]), 32'h0DE);
        chk("chain2_chip1", 32'(ch_b[19:10]), 32'h2AF);

        run_load(2, 20'h1B3, 1'b0);
        chk("slow_latency", 32'(lat), 75);
        chk("slow_hmin", 32'(hmin), 3);
        chk("slow_hmax", 32'(hmax), 3);
        chk("slow_lmin", 32'(lmin), 4);
        chk("slow_chain", 32'(ch_c), 32'h1B3);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
